// File: rtl/ps2_host_tx_if.sv
// Host-side request/response bundle for the PS/2 host transmitter.
// Handshake: tx_data is transferred in a cycle where tx_valid and tx_ready are
// both 1; tx_valid seen while tx_ready is 0 is dropped (nothing is queued).
// done and err are single-cycle completion pulses and never coincide.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       done;
   logic       err;

   modport master (output tx_data, output tx_valid,
                   input  tx_ready, input done, input err);
   modport slave  (input  tx_data, input tx_valid,
                   output tx_ready, output done, output err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte out on device clock falling edges, checks the device
// ACK and waits for the bus to return idle. Line outputs are open-collector
// enables (1 = pull low). o_dbg_state exposes the FSM state
// (0 IDLE, 1 INHIBIT, 2 REQ, 3 SHIFT, 4 ACK, 5 WAITIDLE).
// INHIBIT_CYCLES must be at least 2 so the data line can drop one cycle early.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 375000,
   parameter int FILT_LEN       = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   ps2_host_tx_if.slave bus,
   input  logic         ps2_clk_i,
   input  logic         ps2_data_i,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe,
   output logic [2:0]   o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_REQ      = 3'd2,
      S_SHIFT    = 3'd3,
      S_ACK      = 3'd4,
      S_WAITIDLE = 3'd5
   } state_t;

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(FILT_LEN + 1);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);

   logic             r_clk_s1, r_clk_s2;
   logic             r_dat_s1, r_dat_s2;
   logic             r_filt_clk, r_filt_d;
   logic [FW-1:0]    r_filt_cnt;

   state_t           r_state;
   logic [9:0]       r_frame;     // {stop, parity, data[7:0]}
   logic [3:0]       r_bit_idx;
   logic [CNT_W-1:0] r_cnt;       // inhibit length, then inter-edge timeout
   logic             r_clk_oe, r_data_oe, r_done, r_err;

   logic             w_edge;
   logic             w_active;

   // Two-flop synchronizers for both raw bus lines; idle bus level is 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_i;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Clock deglitch: the filtered level flips only after FILT_LEN consecutive
   // samples disagreeing with it; any agreeing sample restarts the run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt_clk <= 1'b1;
         r_filt_d   <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_filt_d <= r_filt_clk;
         if (r_clk_s2 == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FILT_LAST) begin
            r_filt_clk <= r_clk_s2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   assign w_edge   = r_filt_d & ~r_filt_clk;
   assign w_active = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                     (r_state == S_ACK) || (r_state == S_WAITIDLE);

   // Transfer sequencer with registered line enables and completion pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_frame   <= '0;
         r_bit_idx <= '0;
         r_cnt     <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;

         // Timeout counter restarts on every device edge while the device owns the clock.
         if (w_active) begin
            if (w_edge) r_cnt <= '0;
            else        r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               if (bus.tx_valid) begin
                  r_frame  <= {1'b1, ~^bus.tx_data, bus.tx_data};
                  r_cnt    <= '0;
                  r_clk_oe <= 1'b1;
                  r_state  <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == INH_PRE) r_data_oe <= 1'b1;
               if (r_cnt == INH_LAST) begin
                  r_clk_oe <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               if (w_edge) begin
                  r_data_oe <= ~r_frame[0];
                  r_bit_idx <= 4'd1;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_edge) begin
                  r_data_oe <= ~r_frame[r_bit_idx];
                  r_bit_idx <= r_bit_idx + 4'd1;
                  if (r_bit_idx == 4'd9) r_state <= S_ACK;
               end
            end
            S_ACK: begin
               if (w_edge) begin
                  if (!r_dat_s2) begin
                     r_state <= S_WAITIDLE;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WAITIDLE: begin
               if (r_filt_clk && r_dat_s2) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase

         // A stalled device aborts the transfer; an edge in the same cycle wins.
         if (w_active && !w_edge && (r_cnt == TO_LAST)) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
         end
      end
   end

   assign ps2_clk_oe   = r_clk_oe;
   assign ps2_data_oe  = r_data_oe;
   assign bus.tx_ready = (r_state == S_IDLE);
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign o_dbg_state  = r_state;

endmodule
